nucleotide_packer: RTL
======================

NUCLEOTIDE_PACKER -- requirements
Module: nucleotide_packer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset: asynchronous assert, active-low (0 = reset).
REQ-003 inValid  input  1  inBase/inLast valid this cycle.
REQ-004 inBase  input  2  one 2-bit nucleotide code.
REQ-005 inLast  input  1  marks the final base of a sequence; meaningful only with inValid.
REQ-006 inReady  output  1  packer accepts a base this cycle.
REQ-007 outValid  output  1  outData/outCount/outLast hold a packed word.
REQ-008 outReady  input  1  consumer takes the word this cycle.
REQ-009 outData  output  512  packed word of 256 bases.
REQ-010 outCount  output  9  number of valid bases in outData, range 1..256.
REQ-011 outLast  output  1  word ends a sequence (inLast was packed into it).

Function
REQ-012 A base transfer SHALL occur on a rising edge with inValid=1 and inReady=1; an output transfer SHALL occur on a rising edge with outValid=1 and outReady=1.
REQ-013 Accumulator: 512-bit register acc plus 8-bit index cnt (0..255); the k-th accepted base of a word SHALL be written to acc[511-2k:510-2k], so base 0 sits in the MSBs (the same order a left-shift loader consumes).
REQ-014 Unwritten positions of a word SHALL read 0; acc SHALL clear to 0 when a word leaves the accumulator.
REQ-015 A word SHALL complete on acceptance of the base at cnt=255, or of any base with inLast=1, whichever comes first.
REQ-016 On completion, the word including the completing base SHALL be registered in the same edge: outData <= word, outCount <= cnt+1, outLast <= inLast, outValid <= 1, cnt <= 0. Latency is 1 cycle from the completing base to outValid.
REQ-017 inLast at cnt=255 SHALL yield outCount=256, outLast=1.
REQ-018 Non-completing accepted bases SHALL increment cnt and assert no output.
REQ-019 outData/outCount/outLast SHALL stay stable while outValid=1 and outReady=0.
REQ-020 outValid SHALL fall on the output-transfer edge unless a new word is loaded in that same edge.
REQ-021 outReady while outValid=0 SHALL have no effect; inValid=0 SHALL leave all state unchanged.
REQ-022 Sequence boundaries SHALL NOT merge: the base after an inLast starts a new word at position 0.

Reset
REQ-023 While rst=0: outValid=0, outData=0, outCount=0, outLast=0, acc=0, cnt=0, any held word discarded, inReady=0.
REQ-024 Reset asserted mid-word or with a pending output SHALL drop that data; no partial word is emitted after release.
REQ-025 The first transfer SHALL be possible on the first rising edge after rst returns to 1.

Configuration
REQ-026 Macro PACKER_SKID_EN selects output buffering.
REQ-027 Without PACKER_SKID_EN: inReady = rst & ~outValid (combinational); no base is accepted while a word is pending, and peak throughput is 256 bases per 257 cycles.
REQ-028 With PACKER_SKID_EN: one additional 512+9+1-bit hold register with holdValid SHALL exist, and inReady = rst & ~holdValid.
REQ-029 With PACKER_SKID_EN, a word that completes while outValid=1 and outReady=0 SHALL go to the hold register; one that completes while the output is empty, or is being taken in that edge, SHALL go directly to the output.
REQ-030 With PACKER_SKID_EN, on an output transfer with holdValid=1, the hold word SHALL move to the output in that edge, outValid stays 1, and holdValid clears; order is always FIFO.
REQ-031 With PACKER_SKID_EN and outReady held 1, throughput SHALL be 1 base per cycle.

Verification
REQ-032 256 bases, base k = k mod 4, outReady=1 -> one word, outData = {128{2'b00,2'b01,2'b10,2'b11}} MSB-first, outCount=256, outLast=0, outValid 1 cycle after the 256th base.
REQ-033 3 bases 2'b11,2'b10,2'b01 with inLast on the third -> outData[511:506]=6'b111001, rest 0, outCount=3, outLast=1; the next sequence's first base lands in outData[511:510].
REQ-034 Full word pending with outReady=0 for 10 cycles -> outData stable; without the macro inReady=0 throughout; with the macro 256 more bases are accepted, then inReady=0 until outReady=1, and the words emerge in order.
REQ-035 rst pulsed low for 1 cycle after 100 bases -> all outputs 0; the next 256 bases form a fresh word with outCount=256.
REQ-036 With the macro, outReady=1 and inValid=1 for 1024 cycles -> 4 words, no stall cycles, outValid gaps = 0.

Source files
------------

// File: rtl/nucleotide_packer.sv
// Packs a stream of 2-bit nucleotide codes into 512-bit words, base 0 in the MSBs.
// Define PACKER_SKID_EN to add a one-word hold register behind the output.
module nucleotide_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    input  logic [1:0]   inBase,
    input  logic         inLast,
    output logic         inReady,
    output logic         outValid,
    input  logic         outReady,
    output logic [511:0] outData,
    output logic [8:0]   outCount,
    output logic         outLast
);
    logic [511:0] acc;
    logic [511:0] word;
    logic [7:0]   cnt;
    logic [8:0]   pos;
    logic [8:0]   word_count;
    logic         accept;
    logic         complete;
    logic         out_fire;

    // Current word with the incoming base merged at its slot.
    always_comb begin
        pos  = 9'd511 - {cnt, 1'b0};
        word = acc;
        word[pos -: 2] = inBase;
    end

    assign word_count = {1'b0, cnt} + 9'd1;
    assign accept     = inValid & inReady;
    assign complete   = accept & (inLast | (cnt == 8'hFF));
    assign out_fire   = outValid & outReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (complete) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= word;
            cnt <= cnt + 8'd1;
        end
    end

`ifdef PACKER_SKID_EN
    logic [511:0] hold_data;
    logic [8:0]   hold_count;
    logic         hold_last;
    logic         hold_valid;

    assign inReady = rst & ~hold_valid;

    // A completing base is never accepted while the hold slot is full,
    // so the hold-to-output move and a new completion cannot collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid   <= 1'b0;
            outData    <= '0;
            outCount   <= '0;
            outLast    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_count <= '0;
            hold_last  <= 1'b0;
        end else if (out_fire) begin
            if (hold_valid) begin
                outData    <= hold_data;
                outCount   <= hold_count;
                outLast    <= hold_last;
                hold_valid <= 1'b0;
            end else if (complete) begin
                outData  <= word;
                outCount <= word_count;
                outLast  <= inLast;
            end else begin
                outValid <= 1'b0;
            end
        end else if (complete) begin
            if (outValid) begin
                hold_data  <= word;
                hold_count <= word_count;
                hold_last  <= inLast;
                hold_valid <= 1'b1;
            end else begin
                outData  <= word;
                outCount <= word_count;
                outLast  <= inLast;
                outValid <= 1'b1;
            end
        end
    end
`else
    assign inReady = rst & ~outValid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid <= 1'b0;
            outData  <= '0;
            outCount <= '0;
            outLast  <= 1'b0;
        end else if (complete) begin
            outData  <= word;
            outCount <= word_count;
            outLast  <= inLast;
            outValid <= 1'b1;
        end else if (out_fire) begin
            outValid <= 1'b0;
        end
    end
`endif

endmodule
